// File: rtl/cpu_int_seq_if.sv
// Decoder-facing bus of the interrupt entry sequencer.
// master = decoder/core side, slave = cpu_int_seq.
interface cpu_int_seq_if;
  logic        stall;
  logic        sync;
  logic        brk_op;
  logic        nmi_n;
  logic        irq_n;
  logic        i_flag;
  logic [7:0]  sp;
  logic [7:0]  int_sel;
  logic        busy;
  logic [15:0] addr;
  logic        push_en;
  logic [1:0]  push_sel;
  logic        b_push;
  logic        sp_dec;
  logic        set_i;
  logic        done;

  modport master (
    output stall, sync, brk_op, nmi_n, irq_n, i_flag, sp,
    input  int_sel, busy, addr, push_en, push_sel, b_push, sp_dec, set_i, done
  );

  modport slave (
    input  stall, sync, brk_op, nmi_n, irq_n, i_flag, sp,
    output int_sel, busy, addr, push_en, push_sel, b_push, sp_dec, set_i, done
  );
endinterface

// File: rtl/cpu_int_seq.sv
// 6502 RST/NMI/IRQ/BRK entry sequencer: 7 non-stalled cycles from sync to done.
// stall freezes state and outputs (strobes forced low); NMI edge detection keeps running.
module cpu_int_seq #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] RST_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input  logic         clk,
  input  logic         rst,
  cpu_int_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
  } state_t;

  localparam logic [2:0] SRC_NONE = 3'd0;
  localparam logic [2:0] SRC_NMI  = 3'd1;
  localparam logic [2:0] SRC_RST  = 3'd2;
  localparam logic [2:0] SRC_IRQ  = 3'd3;
  localparam logic [2:0] SRC_BRK  = 3'd4;

  state_t      state_q, state_d;
  logic [2:0]  src_q, src_d;
  logic [15:0] vec_q, vec_d;
  logic        rst_pend_q, rst_pend_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        nmi_prev_q;
  logic        nmi_fall;
  logic        nmi_clr;
  logic        irq_req;
  logic        push_phase;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    vec_d      = vec_q;
    rst_pend_d = rst_pend_q;
    nmi_clr    = 1'b0;
    nmi_fall   = nmi_prev_q & ~bus.nmi_n;
    irq_req    = ~bus.irq_n & ~bus.i_flag;

    if (!bus.stall) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.sync && (rst_pend_q || nmi_pend_q || irq_req || bus.brk_op)) begin
            state_d = S_T1;
            if (rst_pend_q) begin
              src_d      = SRC_RST;
              rst_pend_d = 1'b0;
            end else if (nmi_pend_q) begin
              src_d = SRC_NMI;
            end else if (irq_req) begin
              src_d = SRC_IRQ;
            end else begin
              src_d = SRC_BRK;
            end
          end
        end
        S_T5: begin
          // Vector is resolved against the pending flag as seen during T6, so an
          // NMI edge caught on this step still hijacks an IRQ/BRK entry.
          state_d = S_T6;
          if (src_q == SRC_RST) begin
            vec_d = RST_VEC;
          end else if (nmi_pend_q || nmi_fall) begin
            vec_d = NMI_VEC;
            src_d = SRC_NMI;
          end else begin
            vec_d = IRQ_VEC;
          end
        end
        S_T6: begin
          state_d = S_T7;
          nmi_clr = (vec_q == NMI_VEC);
        end
        S_T7: begin
          state_d = S_IDLE;
          src_d   = SRC_NONE;
        end
        default: state_d = state_t'(state_q + 3'd1);
      endcase
    end

    // A new edge wins over a simultaneous clear.
    nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= SRC_NONE;
      vec_q      <= 16'h0000;
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      vec_q      <= vec_d;
      rst_pend_q <= rst_pend_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= bus.nmi_n;
    end
  end

  assign push_phase = (state_q == S_T3) || (state_q == S_T4) || (state_q == S_T5);

  always_comb begin
    bus.addr     = 16'h0000;
    bus.push_sel = 2'd0;
    unique case (state_q)
      S_T3:    begin bus.addr = {8'h01, bus.sp}; bus.push_sel = 2'd0; end
      S_T4:    begin bus.addr = {8'h01, bus.sp}; bus.push_sel = 2'd1; end
      S_T5:    begin bus.addr = {8'h01, bus.sp}; bus.push_sel = 2'd2; end
      S_T6:    bus.addr = vec_q;
      S_T7:    bus.addr = vec_q + 16'd1;
      default: bus.addr = 16'h0000;
    endcase
  end

  assign bus.int_sel = {5'd0, src_q};
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.b_push  = (src_q == SRC_BRK);
  assign bus.push_en = ~bus.stall & push_phase & (src_q != SRC_RST);
  assign bus.sp_dec  = ~bus.stall & push_phase;
  assign bus.set_i   = ~bus.stall & (state_q == S_T7);
  assign bus.done    = ~bus.stall & (state_q == S_T7);

endmodule

// File: tb/tb_cpu_int_seq.sv
// Directed bench for cpu_int_seq: RST/IRQ/BRK/NMI entries, NMI hijack, stall and mid-sequence reset.
module tb_cpu_int_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cpu_int_seq_if bus ();

  cpu_int_seq #(
    .NMI_VEC(16'hFFFA),
    .RST_VEC(16'hFFFC),
    .IRQ_VEC(16'hFFFE)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks T1..T7 after the start edge and checks every output against the
  // hand-derived cycle table. Optional NMI edge, 3-cycle stall and reset injection.
  task automatic seq_check(input string tag, input logic [7:0] src, input logic [7:0] src6,
                           input logic [15:0] vec, input logic [7:0] spv, input logic pe,
                           input logic bp, input int nmi_at, input int stall_at, input int rst_at);
    int          cyc;
    logic [15:0] e_addr;
    logic [1:0]  e_sel;
    logic        in_push;
    bus.sync   = 1'b0;
    bus.brk_op = 1'b0;
    cyc = 1;
    for (int t = 1; t <= 7; t++) begin
      in_push = (t >= 3) && (t <= 5);
      e_addr  = (t <= 2) ? 16'h0000 : in_push ? {8'h01, spv} : (t == 6) ? vec : vec + 16'd1;
      e_sel   = (t == 4) ? 2'd1 : (t == 5) ? 2'd2 : 2'd0;
      if (t == stall_at) begin
        bus.stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("%s_T%0d_stall%0d_addr", tag, t, k), bus.addr, e_addr);
          chk($sformatf("%s_T%0d_stall%0d_spdec", tag, t, k), {15'd0, bus.sp_dec}, 16'd0);
          chk($sformatf("%s_T%0d_stall%0d_pushen", tag, t, k), {15'd0, bus.push_en}, 16'd0);
          chk($sformatf("%s_T%0d_stall%0d_busy", tag, t, k), {15'd0, bus.busy}, 16'd1);
          tick();
          cyc++;
        end
        bus.stall = 1'b0;
        #1;
      end
      chk($sformatf("%s_T%0d_int_sel", tag, t), {8'd0, bus.int_sel}, {8'd0, (t >= 6) ? src6 : src});
      chk($sformatf("%s_T%0d_busy", tag, t), {15'd0, bus.busy}, 16'd1);
      chk($sformatf("%s_T%0d_addr", tag, t), bus.addr, e_addr);
      chk($sformatf("%s_T%0d_push_en", tag, t), {15'd0, bus.push_en}, {15'd0, in_push & pe});
      chk($sformatf("%s_T%0d_push_sel", tag, t), {14'd0, bus.push_sel}, {14'd0, e_sel});
      chk($sformatf("%s_T%0d_b_push", tag, t), {15'd0, bus.b_push}, {15'd0, bp});
      chk($sformatf("%s_T%0d_sp_dec", tag, t), {15'd0, bus.sp_dec}, {15'd0, in_push});
      chk($sformatf("%s_T%0d_set_i", tag, t), {15'd0, bus.set_i}, {15'd0, t == 7});
      chk($sformatf("%s_T%0d_done", tag, t), {15'd0, bus.done}, {15'd0, t == 7});
      if (t == 7)
        chk($sformatf("%s_done_cycle", tag), cyc[15:0], (stall_at > 0) ? 16'd10 : 16'd7);
      if (t == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk($sformatf("%s_rst_busy", tag), {15'd0, bus.busy}, 16'd0);
        chk($sformatf("%s_rst_int_sel", tag), {8'd0, bus.int_sel}, 16'd0);
        return;
      end
      if (t == nmi_at) bus.nmi_n = 1'b0;
      tick();
      cyc++;
    end
    chk($sformatf("%s_idle_busy", tag), {15'd0, bus.busy}, 16'd0);
    chk($sformatf("%s_idle_int_sel", tag), {8'd0, bus.int_sel}, 16'd0);
    chk($sformatf("%s_idle_done", tag), {15'd0, bus.done}, 16'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.stall  = 1'b0;
    bus.sync   = 1'b0;
    bus.brk_op = 1'b0;
    bus.nmi_n  = 1'b1;
    bus.irq_n  = 1'b1;
    bus.i_flag = 1'b1;
    bus.sp     = 8'hFD;
    tick();
    tick();
    chk("reset_busy", {15'd0, bus.busy}, 16'd0);
    chk("reset_int_sel", {8'd0, bus.int_sel}, 16'd0);
    chk("reset_addr", bus.addr, 16'h0000);
    chk("reset_push_en", {15'd0, bus.push_en}, 16'd0);
    chk("reset_push_sel", {14'd0, bus.push_sel}, 16'd0);
    chk("reset_b_push", {15'd0, bus.b_push}, 16'd0);
    chk("reset_sp_dec", {15'd0, bus.sp_dec}, 16'd0);
    chk("reset_set_i", {15'd0, bus.set_i}, 16'd0);
    chk("reset_done", {15'd0, bus.done}, 16'd0);

    // Reset entry: pushes suppressed, vector FFFC/FFFD.
    rst      = 1'b0;
    bus.sync = 1'b1;
    tick();
    seq_check("rst_entry", 8'd2, 8'd2, 16'hFFFC, 8'hFD, 1'b0, 1'b0, 0, 0, 0);

    // IRQ entry with I clear.
    bus.sp     = 8'hF0;
    bus.irq_n  = 1'b0;
    bus.i_flag = 1'b0;
    bus.sync   = 1'b1;
    tick();
    seq_check("irq_entry", 8'd3, 8'd3, 16'hFFFE, 8'hF0, 1'b1, 1'b0, 0, 0, 0);

    // IRQ masked by I: no entry.
    bus.i_flag = 1'b1;
    bus.sync   = 1'b1;
    tick();
    chk("irq_masked_busy0", {15'd0, bus.busy}, 16'd0);
    tick();
    chk("irq_masked_busy1", {15'd0, bus.busy}, 16'd0);
    bus.sync = 1'b0;

    // BRK together with IRQ: IRQ wins, BRK discarded.
    bus.i_flag = 1'b0;
    bus.brk_op = 1'b1;
    bus.sync   = 1'b1;
    tick();
    seq_check("brk_irq", 8'd3, 8'd3, 16'hFFFE, 8'hF0, 1'b1, 1'b0, 0, 0, 0);

    // BRK alone.
    bus.irq_n  = 1'b1;
    bus.sp     = 8'hE8;
    bus.brk_op = 1'b1;
    bus.sync   = 1'b1;
    tick();
    seq_check("brk_only", 8'd4, 8'd4, 16'hFFFE, 8'hE8, 1'b1, 1'b1, 0, 0, 0);

    // NMI edge during T4 of an IRQ entry hijacks the vector.
    bus.sp    = 8'hF0;
    bus.irq_n = 1'b0;
    bus.sync  = 1'b1;
    tick();
    seq_check("nmi_hijack", 8'd3, 8'd1, 16'hFFFA, 8'hF0, 1'b1, 1'b0, 4, 0, 0);

    // NMI line still low but no new edge: nothing pending.
    bus.irq_n  = 1'b1;
    bus.i_flag = 1'b1;
    bus.sync   = 1'b1;
    tick();
    chk("nmi_no_reentry_busy", {15'd0, bus.busy}, 16'd0);
    bus.sync  = 1'b0;
    bus.nmi_n = 1'b1;
    tick();

    // Stall for 3 cycles in T4 of an IRQ entry.
    bus.sp     = 8'hC4;
    bus.irq_n  = 1'b0;
    bus.i_flag = 1'b0;
    bus.sync   = 1'b1;
    tick();
    seq_check("irq_stall", 8'd3, 8'd3, 16'hFFFE, 8'hC4, 1'b1, 1'b0, 0, 4, 0);
    bus.irq_n = 1'b1;

    // NMI entry interrupted by reset in T5, then the reset entry follows.
    bus.nmi_n = 1'b0;
    tick();
    bus.nmi_n = 1'b1;
    bus.sp    = 8'hB0;
    bus.sync  = 1'b1;
    tick();
    seq_check("nmi_rst", 8'd1, 8'd1, 16'hFFFA, 8'hB0, 1'b1, 1'b0, 0, 0, 5);
    bus.sync = 1'b1;
    tick();
    seq_check("rst_after", 8'd2, 8'd2, 16'hFFFC, 8'hB0, 1'b0, 1'b0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_int_seq.md
Name: cpu_int_seq

Overview:
- 6502 interrupt/reset entry sequencer for the Famicom CPU core. Sits directly upstream of the register file.
- Detects RST/NMI/IRQ/BRK at instruction boundaries and runs the 7-cycle entry sequence. During the sequence it drives the register file's int_sel, the stack push strobes and the vector fetch addresses.
- The decoder hands control to this block at sync and resumes at done.

Parameters:
- NMI_VEC, 16'hFFFA, NMI vector low-byte address
- RST_VEC, 16'hFFFC, reset vector low-byte address
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; synchronous, active-high
- stall  in  1  freezes sequencer state and outputs; edge detection keeps running
- sync  in  1  instruction boundary (opcode-fetch cycle)
- brk_op  in  1  decoder reports BRK opcode at sync
- nmi_n  in  1  NMI line, active-low, edge-triggered
- irq_n  in  1  IRQ line, active-low, level
- i_flag  in  1  status I flag
- sp  in  8  current stack pointer
- int_sel  out  8  source to register file: 0 none, 1 NMI, 2 RST, 3 IRQ, 4 BRK
- busy  out  1  sequence in progress (T1..T7)
- addr  out  16  bus address during sequence
- push_en  out  1  stack write strobe
- push_sel  out  2  0 PCH, 1 PCL, 2 P
- b_push  out  1  B bit value for pushed P
- sp_dec  out  1  decrement SP this cycle
- set_i  out  1  set I flag
- done  out  1  one-cycle pulse; sequence complete

Behaviour:
- Reset values:
  - state IDLE; int_sel=0; busy=0; addr=0; push_en=0; push_sel=0; b_push=0; sp_dec=0; set_i=0; done=0.
  - Internally: rst_pend=1, nmi_pend=0, nmi_prev=1.
- NMI detect:
  - nmi_prev<=nmi_n every clock, including stall cycles.
  - nmi_prev=1 & nmi_n=0 sets nmi_pend.
  - nmi_pend clears on the T6 step that uses NMI_VEC.
  - An edge arriving in the same cycle as that clear stays pending.
- IRQ request: irq_req = ~irq_n & ~i_flag, evaluated combinationally at sync.
- Start condition: in IDLE with sync=1, stall=0 and any source present, go to T1 and latch the source.
  - Priority: RST > NMI > IRQ > BRK.
  - If brk_op=1 and a higher source wins, the BRK is discarded; the decoder re-fetches it after done.
- States advance T1->T7, one state per non-stalled clock, then return to IDLE. Latency from start to done is 7 non-stalled cycles.
  - T1, T2: dummy cycles, addr=0, no strobes.
  - T3: addr={8'h01,sp}, push_sel=0, sp_dec=1.
  - T4: addr={8'h01,sp}, push_sel=1, sp_dec=1.
  - T5: addr={8'h01,sp}, push_sel=2, sp_dec=1.
  - push_en=1 in T3..T5, except when the source is RST: pushes are suppressed (push_en=0) but sp_dec still pulses.
  - T6: addr=vector low. The vector is chosen here: RST_VEC if the source is RST; otherwise NMI_VEC if nmi_pend=1 (NMI hijack of IRQ/BRK); otherwise IRQ_VEC.
  - T6: if NMI hijacks, int_sel changes to 1 from this cycle on.
  - T7: addr=vector+1, set_i=1, done=1.
- int_sel holds the source code from T1 through T7 and is 0 in IDLE. busy=1 in T1..T7.
- b_push=1 only when the source is BRK; otherwise 0.
- stall=1: state and all outputs hold their values; the strobes (push_en, sp_dec, set_i, done) are gated to 0.
- Reset mid-sequence: return to IDLE with reset values; rst_pend=1 so the next sync runs the RST sequence.
- Vector arithmetic is 16-bit; vector+1 wraps modulo 2^16.

Test Plan:
- Post-reset, sync=1 at cycle 1, sp=8'hFD:
  - int_sel=2 for 7 cycles, push_en never 1, sp_dec=1 in T3..T5.
  - addr 16'hFFFC then 16'hFFFD; done pulses in T7.
- irq_n=0, i_flag=0, sync=1, sp=8'hF0:
  - addr 16'h01F0 at T3..T5, push_sel 0,1,2, b_push=0.
  - addr 16'hFFFE, 16'hFFFF; set_i=1 at T7.
  - Repeat with i_flag=1: busy stays 0.
- nmi_n high->low while an IRQ sequence is in T4:
  - T6 addr=16'hFFFA, int_sel switches 3->1, nmi_pend cleared.
  - A further NMI edge is required for a second entry.
- brk_op=1 and irq_n=0 (i_flag=0) at the same sync: int_sel=3, b_push=0.
  - brk_op alone: int_sel=4, b_push=1, vector 16'hFFFE.
- stall=1 for 3 cycles during T4:
  - addr held, no extra sp_dec.
  - done arrives 3 cycles later than unstalled (10 cycles after start).
- rst=1 during T5 of an NMI sequence:
  - busy=0 next cycle.
  - Next sync runs the RST sequence (int_sel=2, addr 16'hFFFC).
